// File: rtl/membus_pkg.sv
// Shared definitions for the memory-bus RAM controller: FSM state encoding
// and default bus widths.
package membus_pkg;

  localparam int DEF_DATA_WIDTH = 36;
  localparam int DEF_ADDR_WIDTH = 14;

  typedef enum logic [2:0] {
    IDLE,
    ACK,
    RD,
    RDRS,
    WRWAIT,
    WRITE,
    DONE
  } state_t;

endpackage

// File: rtl/membus_sync.sv
// Registers the bus request/restart strobes and derives a new-request pulse
// and the wr_rs rising edge used by the controller FSM.
module membus_sync (
  input  logic clk,
  input  logic reset,
  input  logic rq_cyc,
  input  logic rd_rq,
  input  logic wr_rq,
  input  logic wr_rs,
  output logic req_start,
  output logic wr_rs_rise
);

  logic rq_cyc_q;
  logic rd_rq_q;
  logic wr_rq_q;
  logic wr_rs_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rq_cyc_q <= 1'b0;
      rd_rq_q  <= 1'b0;
      wr_rq_q  <= 1'b0;
      wr_rs_q  <= 1'b0;
    end else begin
      rq_cyc_q <= rq_cyc;
      rd_rq_q  <= rd_rq;
      wr_rq_q  <= wr_rq;
      wr_rs_q  <= wr_rs;
    end
  end

  // A request counts only once per bus cycle; the master must drop rq_cyc
  // before the same request can be seen again.
  assign req_start  = rq_cyc & (rd_rq | wr_rq) & ~(rq_cyc_q & (rd_rq_q | wr_rq_q));
  assign wr_rs_rise = wr_rs & ~wr_rs_q;

endmodule

// File: rtl/core_ram_ctl.sv
// Memory-bus to single-port synchronous RAM controller (read, write, RMW).
// Define CORE_RAM_ADDR_CHECK_EN to ignore requests with ma >= MEM_WORDS.
module core_ram_ctl
  import membus_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int MEM_WORDS  = 2**ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  membus_rq_cyc,
  input  logic                  membus_rd_rq,
  input  logic                  membus_wr_rq,
  input  logic [ADDR_WIDTH-1:0] membus_ma,
  input  logic                  membus_wr_rs,
  input  logic [DATA_WIDTH-1:0] membus_mb_in,
  output logic                  membus_addr_ack,
  output logic                  membus_rd_rs,
  output logic [DATA_WIDTH-1:0] membus_mb_out,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_data,
  output logic                  ram_we,
  input  logic [DATA_WIDTH-1:0] ram_q
);

  state_t                state, nxt;
  logic [ADDR_WIDTH-1:0] ma_r;
  logic                  rd_l, wr_l;
  logic                  req_start, wr_rs_rise, addr_ok;
  logic                  accept, load_q, load_wd;

  membus_sync u_sync (
    .clk        (clk),
    .reset      (reset),
    .rq_cyc     (membus_rq_cyc),
    .rd_rq      (membus_rd_rq),
    .wr_rq      (membus_wr_rq),
    .wr_rs      (membus_wr_rs),
    .req_start  (req_start),
    .wr_rs_rise (wr_rs_rise)
  );

`ifdef CORE_RAM_ADDR_CHECK_EN
  localparam logic [31:0] MEM_LIMIT = 32'(MEM_WORDS);
  assign addr_ok = (32'(membus_ma) < MEM_LIMIT);
`else
  assign addr_ok = 1'b1;
`endif

  always_comb begin
    nxt     = state;
    accept  = 1'b0;
    load_q  = 1'b0;
    load_wd = 1'b0;
    case (state)
      IDLE: begin
        if (req_start && addr_ok) begin
          accept = 1'b1;
          nxt    = ACK;
        end
      end
      ACK:    nxt = !membus_rq_cyc ? IDLE : (rd_l ? RD : WRWAIT);
      RD: begin
        if (!membus_rq_cyc) nxt = IDLE;
        else begin
          load_q = 1'b1;
          nxt    = RDRS;
        end
      end
      RDRS:   nxt = !membus_rq_cyc ? IDLE : (wr_l ? WRWAIT : DONE);
      WRWAIT: begin
        if (!membus_rq_cyc) nxt = IDLE;
        else if (wr_rs_rise) begin
          load_wd = 1'b1;
          nxt     = WRITE;
        end
      end
      WRITE:  nxt = !membus_rq_cyc ? IDLE : DONE;
      DONE:   if (!membus_rq_cyc) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      ma_r          <= '0;
      rd_l          <= 1'b0;
      wr_l          <= 1'b0;
      ram_data      <= '0;
      membus_mb_out <= '0;
    end else begin
      state <= nxt;
      if (accept) begin
        ma_r <= membus_ma;
        rd_l <= membus_rd_rq;
        wr_l <= membus_wr_rq;
      end
      if (load_q)  membus_mb_out <= ram_q;
      if (load_wd) ram_data      <= membus_mb_in;
    end
  end

  // Gating we with rq_cyc keeps an abort in the WRITE cycle from storing.
  assign membus_addr_ack = (state == ACK);
  assign membus_rd_rs    = (state == RDRS);
  assign ram_we          = (state == WRITE) && membus_rq_cyc;
  assign ram_addr        = ma_r;

endmodule
